argmax_onehot_enc: RTL
======================

Name: argmax_onehot_enc

Overview:
- Output-stage encoder for the digit classifier; the inverse of the one-hot-input neuron.
- Takes a packed vector of N signed fixed-point neuron outputs and scans it sequentially, one comparison per cycle.
- Produces a one-hot class vector, the binary class index and the winning value.
- Uses the same start/ack/done handshake as the neuron blocks, so it chains directly after the last layer.

Parameters:
- WIDTH, 8, bit width of each signed neuron output; fixed-point position is irrelevant because only order is compared.
- N, 10, number of classes / inputs; must be >= 1.
- IDXW, 4, index width; must satisfy 2**IDXW >= N.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled on clk.
- Y  in  N*WIDTH  packed signed inputs; element i = Y[i*WIDTH +: WIDTH]; sampled only on the accepting edge.
- ack  out  1  registered, one-cycle pulse confirming acceptance.
- done  out  1  registered, one-cycle pulse; result valid.
- busy  out  1  high while scanning.
- onehot  out  N  one-hot class, bit idx set.
- idx  out  IDXW  winning class index.
- max_val  out  WIDTH  signed winning value.

Behaviour:
- Reset (async): state=IDLE; ack, done, busy, onehot, idx, max_val all 0; internal copy of Y cleared.
- States:
  - IDLE: idle.
  - SCAN: comparing.
  - FIN: publishing the result.
- Acceptance:
  - start is accepted on an edge where state is IDLE or FIN.
  - On acceptance: latch Y locally, best_val=Y[0], best_idx=0, cnt=1, ack=1 for the following cycle.
  - Next state is SCAN, or FIN directly if N==1.
- start is ignored while in SCAN: no ack, the scan is not disturbed, and the latched data is unchanged.
- SCAN, each edge:
  - Compare element cnt against best_val as signed values.
  - Replace best only if strictly greater, so ties resolve to the lowest index.
  - cnt increments. After element N-1 is compared, go to FIN.
- FIN entry edge:
  - Register onehot = 1<<best_idx, idx = best_idx, max_val = best_val.
  - done=1 for exactly one cycle.
  - FIN lasts one cycle, then returns to IDLE unless start was accepted on that edge, which gives back-to-back operation.
- Outputs onehot/idx/max_val hold their values until the next FIN. They are never cleared except by rst.
- busy=1 exactly while state==SCAN.
- Latency:
  - Start accepted at edge 0: ack is high during cycle 0→1.
  - done is high in the cycle after edge N, i.e. N cycles after acceptance. For N=1 this is edge 1.
  - Throughput: one result per N cycles when start is held high.
- Arithmetic:
  - Pure signed WIDTH-bit magnitude compare; no widening needed.
  - -2**(WIDTH-1) is a legal input.
  - onehot always has exactly one bit set after the first completion.
- Reset mid-operation:
  - Aborts the scan immediately.
  - No done is produced for the aborted request.
  - All outputs return to 0.

Decomposition:
- Shared package:
  - State encoding constants IDLE/SCAN/FIN.
  - A clog2 function for deriving IDXW.
  - Default WIDTH/N for the classifier.
- Sub-module argmax_cmp:
  - Combinational signed compare of the candidate against best.
  - Outputs the greater flag and the next best_val/best_idx.
  - Keeps the FSM/datapath file small.

Test Plan:
- N=10, WIDTH=8. Y = {10,10,10,10,10,10,10,100,10,10} (element 7 = 100), start for 1 cycle -> ack next cycle; done exactly 10 cycles after acceptance; onehot=10'h080, idx=7, max_val=100; busy high 9 cycles.
- Tie: elements 2 and 5 = 50, rest = 0 -> idx=2, onehot=10'h004.
- All negative: elements 0..8 = -128, element 9 = -3 -> idx=9, onehot=10'h200, max_val=-3. Confirms signed compare.
- Second start pulse 3 cycles into a scan, with different Y -> no second ack; result matches the first Y; exactly one done.
- rst asserted 4 cycles into a scan -> outputs immediately 0, no done; a new start after release gives the correct result for the new Y.
- start held high with two alternating Y vectors (idx 3, then idx 8) -> done pulses every 10 cycles; outputs idx=3 then idx=8; ack coincides with the cycle after each FIN edge.

Source files
------------

// File: rtl/argmax_onehot_enc_pkg.sv
// Shared definitions for the classifier output-stage argmax encoder.
// Latency: n/a. Backpressure: n/a.
package argmax_onehot_enc_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_N     = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Index width for N classes; never returns less than 1 so N==1 still has a port.
    function automatic int clog2_f(input int val);
        int r = 1;
        while ((1 << r) < val) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Signed candidate-versus-best compare for the argmax scan.
// Latency: combinational. Backpressure: none.
module argmax_cmp
    import argmax_onehot_enc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDXW  = clog2_f(DEF_N)
) (
    input  logic signed [WIDTH-1:0] cand_val,
    input  logic        [IDXW-1:0]  cand_idx,
    input  logic signed [WIDTH-1:0] best_val,
    input  logic        [IDXW-1:0]  best_idx,
    output logic                    gt,
    output logic signed [WIDTH-1:0] nxt_val,
    output logic        [IDXW-1:0]  nxt_idx
);

    // Strictly greater keeps the earlier (lower) index on ties.
    assign gt      = cand_val > best_val;
    assign nxt_val = gt ? cand_val : best_val;
    assign nxt_idx = gt ? cand_idx : best_idx;

endmodule

// File: rtl/argmax_onehot_enc.sv
// Sequential argmax over N signed neuron outputs -> onehot, index and winning value.
// Latency: done N cycles after the accepting edge; one result per N cycles with start held.
// Backpressure: start is only accepted in IDLE or FIN; requests during SCAN are dropped.
module argmax_onehot_enc
    import argmax_onehot_enc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N,
    parameter int IDXW  = clog2_f(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N*WIDTH-1:0]   Y,
    output logic                 ack,
    output logic                 done,
    output logic                 busy,
    output logic [N-1:0]         onehot,
    output logic [IDXW-1:0]      idx,
    output logic [WIDTH-1:0]     max_val
);

    state_t                   state_q, state_d;
    logic [N*WIDTH-1:0]       y_q, y_d;
    logic signed [WIDTH-1:0]  best_val_q, best_val_d;
    logic [IDXW-1:0]          best_idx_q, best_idx_d;
    logic [IDXW-1:0]          cnt_q, cnt_d;
    logic [N-1:0]             onehot_q, onehot_d;
    logic [IDXW-1:0]          idx_q, idx_d;
    logic signed [WIDTH-1:0]  max_val_q, max_val_d;
    logic                     ack_q, ack_d;
    logic                     done_q, done_d;
    logic                     busy_q, busy_d;

    logic                     accept;
    logic signed [WIDTH-1:0]  cand_val;
    logic                     cand_gt;
    logic signed [WIDTH-1:0]  nxt_val;
    logic [IDXW-1:0]          nxt_idx;

    // FIN accepts too, so a held start chains scans without an IDLE bubble.
    assign accept = start && ((state_q == IDLE) || (state_q == FIN));

    always_comb begin
        cand_val = y_q[WIDTH-1:0];
        for (int i = 1; i < N; i++) begin
            if (cnt_q == IDXW'(i)) cand_val = y_q[i*WIDTH +: WIDTH];
        end
    end

    argmax_cmp #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_cmp (
        .cand_val (cand_val),
        .cand_idx (cnt_q),
        .best_val (best_val_q),
        .best_idx (best_idx_q),
        .gt       (cand_gt),
        .nxt_val  (nxt_val),
        .nxt_idx  (nxt_idx)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = IDLE;
            SCAN:    if (cnt_q == IDXW'(N-1)) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) state_d = (N == 1) ? FIN : SCAN;
    end

    always_comb begin
        y_d        = y_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        cnt_d      = cnt_q;
        onehot_d   = onehot_q;
        idx_d      = idx_q;
        max_val_d  = max_val_q;

        if (state_q == SCAN) begin
            if (cand_gt) begin
                best_val_d = nxt_val;
                best_idx_d = nxt_idx;
            end
            cnt_d = cnt_q + IDXW'(1);
        end

        // Publish from the current best even if a new request reloads it on the same edge.
        if (state_q == FIN) begin
            for (int i = 0; i < N; i++) begin
                onehot_d[i] = (best_idx_q == IDXW'(i));
            end
            idx_d     = best_idx_q;
            max_val_d = best_val_q;
        end

        if (accept) begin
            y_d        = Y;
            best_val_d = Y[WIDTH-1:0];
            best_idx_d = '0;
            cnt_d      = IDXW'(1);
        end
    end

    always_comb begin
        ack_d  = accept;
        done_d = (state_q == FIN);
        busy_d = (state_d == SCAN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            y_q        <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
            cnt_q      <= '0;
            onehot_q   <= '0;
            idx_q      <= '0;
            max_val_q  <= '0;
            ack_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            cnt_q      <= cnt_d;
            onehot_q   <= onehot_d;
            idx_q      <= idx_d;
            max_val_q  <= max_val_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign ack     = ack_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign onehot  = onehot_q;
    assign idx     = idx_q;
    assign max_val = max_val_q;

endmodule
